// File: rtl/wav_rec_pkg.sv
// Shared types and helpers for the wave recorder.
// Contents: recorder state encoding, prescaler terminal-count helper,
// and the offset-binary midpoint used by the optional level trigger.
package wav_rec_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        RECORD = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Offset-binary zero level of the 8-bit stored sample
    localparam logic [7:0] MID = 8'h80;

    // Terminal count of the sample-rate prescaler (counts 0..result)
    function automatic int unsigned prescale(input int unsigned clk_hz,
                                             input int unsigned sample_hz);
        return (clk_hz / sample_hz) - 1;
    endfunction

endpackage

// File: rtl/wav_rec_tick.sv
// Sample-rate prescaler for the wave recorder.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clr      : synchronous clear to 0 (has priority over i_en)
//   i_en       : count enable; counter holds while low
//   o_tick_c   : combinational, high in the cycle the count equals PRESCALE
module wav_rec_tick #(
    parameter int unsigned PRESCALE = 2999
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick_c
);

    localparam int unsigned CNT_W = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(PRESCALE);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             at_term_c;

    assign at_term_c = (cnt_q == TERM);
    assign o_tick_c  = i_en & at_term_c;

    // Wrapping 0..PRESCALE counter
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = at_term_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wav_recorder.sv
// Wave recorder: samples the 16-bit offset-binary audio mix at SAMPLE_HZ
// and writes the upper byte into the wave dual-port RAM write port.
// Optional macro WAV_REC_TRIGGER_EN adds an ARMED state that waits for the
// first sample deviating from midpoint by at least TRIG_LEVEL.
// Ports:
//   I_CLK, I_RSTn      : system clock, asynchronous active-low reset
//   I_START, I_STOP    : take control (STOP wins when both are high)
//   I_SAMPLE[15:0]     : audio input, midpoint 16'h8000
//   O_WR_EN/ADDR/DATA  : RAM write port, one strobe per sample
//   O_LENGTH           : samples written in the current/last take
//   O_BUSY             : high in ARMED or RECORD
//   O_FULL             : last take ended on buffer full
//   O_DONE             : one-cycle pulse on entering DONE
module wav_recorder
    import wav_rec_pkg::*;
#(
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned CLK_HZ     = 24000000,
    parameter int unsigned SAMPLE_HZ  = 8000,
    parameter int unsigned TRIG_LEVEL = 8
) (
    input  logic              I_CLK,
    input  logic              I_RSTn,
    input  logic              I_START,
    input  logic              I_STOP,
    input  logic [15:0]       I_SAMPLE,
    output logic              O_WR_EN,
    output logic [ADDR_W-1:0] O_WR_ADDR,
    output logic [7:0]        O_WR_DATA,
    output logic [ADDR_W:0]   O_LENGTH,
    output logic              O_BUSY,
    output logic              O_FULL,
    output logic              O_DONE
);

    localparam int unsigned       PRESCALE  = prescale(CLK_HZ, SAMPLE_HZ);
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W:0]   length_q, length_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              full_q, full_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic              tick_c;
    logic              presc_clr_c;
    logic              presc_en_c;
    logic              write_c;
    logic              accept_c;
    logic [7:0]        sample_hi_c;

    assign sample_hi_c = I_SAMPLE[15:8];
    assign accept_c    = I_START & ~I_STOP;
    assign presc_en_c  = (state_q == ARMED) || (state_q == RECORD);

`ifdef WAV_REC_TRIGGER_EN
    logic [7:0] dev_c;
    logic       trig_hit_c;
    logic       unused_c;

    // Distance of the stored byte from the offset-binary zero level
    assign dev_c      = (sample_hi_c >= MID) ? (sample_hi_c - MID) : (MID - sample_hi_c);
    assign trig_hit_c = (dev_c >= 8'(TRIG_LEVEL));
    assign unused_c   = ^I_SAMPLE[7:0];
`else
    logic unused_c;
    assign unused_c = ^{I_SAMPLE[7:0], 8'(TRIG_LEVEL), MID};
`endif

    wav_rec_tick #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .clk      (I_CLK),
        .rst_n    (I_RSTn),
        .i_clr    (presc_clr_c),
        .i_en     (presc_en_c),
        .o_tick_c (tick_c)
    );

    // State register
    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
`ifdef WAV_REC_TRIGGER_EN
                if (accept_c) state_d = ARMED;
`else
                if (accept_c) state_d = RECORD;
`endif
            end
            ARMED: begin
`ifdef WAV_REC_TRIGGER_EN
                if (I_STOP) begin
                    state_d = DONE;
                end else if (tick_c && trig_hit_c) begin
                    state_d = RECORD;
                end
`else
                state_d = IDLE;
`endif
            end
            RECORD: begin
                // Last address written: the take ends with this sample
                if (I_STOP || (tick_c && (addr_q == ADDR_LAST))) begin
                    state_d = DONE;
                end
            end
        endcase
    end

    // Datapath / output next values
    always_comb begin
        addr_d      = addr_q;
        length_d    = length_q;
        full_d      = full_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = 1'b0;
        presc_clr_c = 1'b0;
        write_c     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (accept_c) begin
                    presc_clr_c = 1'b1;
                    addr_d      = '0;
                    length_d    = '0;
                    full_d      = 1'b0;
                end
            end
            ARMED: begin
`ifdef WAV_REC_TRIGGER_EN
                write_c = tick_c & trig_hit_c & ~I_STOP;
`else
                write_c = 1'b0;
`endif
            end
            RECORD: begin
                // A STOP on the tick still lets this sample complete
                write_c = tick_c;
            end
        endcase

        if (write_c) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = sample_hi_c;
            length_d  = length_q + (ADDR_W + 1)'(1);
            if (addr_q == ADDR_LAST) begin
                full_d = 1'b1;
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end

        done_d = (state_d == DONE) && (state_q != DONE);
        busy_d = (state_d == ARMED) || (state_d == RECORD);
    end

    // Registered outputs and datapath
    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            addr_q    <= '0;
            length_q  <= '0;
            full_q    <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            length_q  <= length_d;
            full_q    <= full_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign O_WR_EN   = wr_en_q;
    assign O_WR_ADDR = wr_addr_q;
    assign O_WR_DATA = wr_data_q;
    assign O_LENGTH  = length_q;
    assign O_BUSY    = busy_q;
    assign O_FULL    = full_q;
    assign O_DONE    = done_q;

endmodule

// File: tb/tb_wav_recorder.sv
// Directed testbench for wav_recorder with PRESCALE=3 and a 16-entry buffer.
// Trigger checks are compiled in when WAV_REC_TRIGGER_EN is defined.
module tb_wav_recorder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [15:0] sample;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [4:0]  length;
    logic        busy;
    logic        full;
    logic        done;

    int total = 0;
    int bad   = 0;

    wav_recorder #(
        .ADDR_W     (4),
        .CLK_HZ     (16),
        .SAMPLE_HZ  (4),
        .TRIG_LEVEL (8)
    ) dut (
        .I_CLK     (clk),
        .I_RSTn    (rst_n),
        .I_START   (start),
        .I_STOP    (stop),
        .I_SAMPLE  (sample),
        .O_WR_EN   (wr_en),
        .O_WR_ADDR (wr_addr),
        .O_WR_DATA (wr_data),
        .O_LENGTH  (length),
        .O_BUSY    (busy),
        .O_FULL    (full),
        .O_DONE    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_addr"},  32'(wr_addr), 32'd0);
        chk({tag, "_data"},  32'(wr_data), 32'd0);
        chk({tag, "_len"},   32'(length), 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_full"},  32'(full), 32'd0);
        chk({tag, "_done"},  32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        sample = 16'h8000;
        repeat (3) step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Full take: first write at cycle 5, then every 4 cycles, stop at full
        sample = 16'hA512;
        pulse_start();
        chk("start_busy", 32'(busy), 32'd1);
        for (int c = 1; c < 5; c++) begin
            chk("pre_first_wr", 32'(wr_en), 32'd0);
            step();
        end
        chk("first_wr_en", 32'(wr_en), 32'd1);
        chk("first_addr", 32'(wr_addr), 32'd0);
        chk("first_data", 32'(wr_data), 32'hA5);
        chk("first_len", 32'(length), 32'd1);
        chk("first_done", 32'(done), 32'd0);
        for (int k = 1; k < 16; k++) begin
            sample = {8'(8'h30 + k), 8'h5A};
            for (int c = 0; c < 3; c++) begin
                step();
                chk("gap_wr_en", 32'(wr_en), 32'd0);
            end
            step();
            chk("wr_en", 32'(wr_en), 32'd1);
            chk("wr_addr", 32'(wr_addr), 32'(k));
            chk("wr_data", 32'(wr_data), 32'(8'h30 + k));
            chk("wr_len", 32'(length), 32'(k + 1));
        end
        chk("full_done", 32'(done), 32'd1);
        chk("full_full", 32'(full), 32'd1);
        chk("full_busy", 32'(busy), 32'd0);
        step();
        chk("full_done_drop", 32'(done), 32'd0);
        chk("full_len_hold", 32'(length), 32'd16);
        chk("full_flag_hold", 32'(full), 32'd1);
        for (int c = 0; c < 8; c++) begin
            chk("no_17th_wr", 32'(wr_en), 32'd0);
            step();
        end

        // Restart from DONE; START mid-take ignored; STOP on 4th tick
        sample = 16'h1100;
        pulse_start();
        chk("restart_full_clr", 32'(full), 32'd0);
        chk("restart_len_clr", 32'(length), 32'd0);
        repeat (4) step();
        chk("r2_w0_en", 32'(wr_en), 32'd1);
        chk("r2_w0_addr", 32'(wr_addr), 32'd0);
        repeat (2) step();
        pulse_start();
        step();
        chk("r2_w1_en", 32'(wr_en), 32'd1);
        chk("r2_w1_addr", 32'(wr_addr), 32'd1);
        repeat (4) step();
        chk("r2_w2_addr", 32'(wr_addr), 32'd2);
        chk("r2_w2_len", 32'(length), 32'd3);
        repeat (3) step();
        stop   = 1'b1;
        sample = 16'h4400;
        step();
        stop = 1'b0;
        chk("stop_w3_en", 32'(wr_en), 32'd1);
        chk("stop_w3_addr", 32'(wr_addr), 32'd3);
        chk("stop_w3_data", 32'(wr_data), 32'h44);
        chk("stop_len", 32'(length), 32'd4);
        chk("stop_done", 32'(done), 32'd1);
        chk("stop_full", 32'(full), 32'd0);
        chk("stop_busy", 32'(busy), 32'd0);
        for (int c = 0; c < 6; c++) begin
            step();
            chk("after_stop_no_wr", 32'(wr_en), 32'd0);
        end
        chk("after_stop_len", 32'(length), 32'd4);

        // Asynchronous reset in the middle of a write cycle
        sample = 16'hC000;
        pulse_start();
        repeat (4) step();
        chk("pre_rst_wr_en", 32'(wr_en), 32'd1);
        chk("pre_rst_data", 32'(wr_data), 32'hC0);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        step();
        rst_n = 1'b1;
        step();

        // START with STOP in IDLE is ignored
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        for (int c = 0; c < 8; c++) begin
            chk("ss_busy", 32'(busy), 32'd0);
            chk("ss_no_wr", 32'(wr_en), 32'd0);
            step();
        end

        // New take after reset starts at address 0
        sample = 16'hD300;
        pulse_start();
        repeat (4) step();
        chk("post_rst_wr_en", 32'(wr_en), 32'd1);
        chk("post_rst_addr", 32'(wr_addr), 32'd0);
        chk("post_rst_data", 32'(wr_data), 32'hD3);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("post_rst_done", 32'(done), 32'd1);

`ifdef WAV_REC_TRIGGER_EN
        // Level trigger: 0x82 and 0x7C are inside the dead band, 0x89 is not
        step();
        sample = 16'h8200;
        pulse_start();
        for (int c = 1; c < 13; c++) begin
            if (c == 5) sample = 16'h7C00;
            if (c == 9) sample = 16'h8900;
            chk("armed_no_wr", 32'(wr_en), 32'd0);
            chk("armed_busy", 32'(busy), 32'd1);
            step();
        end
        chk("trig_wr_en", 32'(wr_en), 32'd1);
        chk("trig_addr", 32'(wr_addr), 32'd0);
        chk("trig_data", 32'(wr_data), 32'h89);
        chk("trig_len", 32'(length), 32'd1);
        stop = 1'b1;
        step();
        stop = 1'b0;

        // STOP while still armed
        sample = 16'h8000;
        pulse_start();
        repeat (2) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("armed_stop_done", 32'(done), 32'd1);
        chk("armed_stop_len", 32'(length), 32'd0);
        chk("armed_stop_busy", 32'(busy), 32'd0);
        chk("armed_stop_wr", 32'(wr_en), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wav_recorder.md
Name: wav_recorder

Overview:
- Captures the mixed 16-bit unsigned audio stream at a fixed sample rate and writes 8-bit samples into the wave dual-port RAM.
- Playback counterpart: it fills the buffer that the wave player/DMA reader later streams back out.
- Sits on clk_sys, beside the romwav download path, and drives the RAM's write port.

Parameters:
- ADDR_W, 14, RAM address width; capacity is 2^ADDR_W samples.
- CLK_HZ, 24000000, I_CLK frequency.
- SAMPLE_HZ, 8000, capture rate; PRESCALE = CLK_HZ/SAMPLE_HZ - 1 (integer division).
- TRIG_LEVEL, 8, trigger threshold; used only with WAV_REC_TRIGGER_EN.

Ports:
- I_CLK  in  1  system clock.
- I_RSTn  in  1  asynchronous, active-low reset.
- I_START  in  1  start pulse; accepted in IDLE or DONE.
- I_STOP  in  1  stop request.
- I_SAMPLE  in  16  unsigned offset-binary audio, midpoint 16'h8000.
- O_WR_EN  out  1  RAM write strobe, one cycle per sample.
- O_WR_ADDR  out  ADDR_W  RAM write address.
- O_WR_DATA  out  8  sample byte, I_SAMPLE[15:8].
- O_LENGTH  out  ADDR_W+1  samples written in the current/last take.
- O_BUSY  out  1  high in ARMED or RECORD.
- O_FULL  out  1  last take ended on buffer full.
- O_DONE  out  1  one-cycle pulse on entering DONE.

Behaviour:
- Reset: state IDLE; prescaler 0; all outputs 0. Reset is asynchronous and active-low, and a reset mid-take drops O_WR_EN immediately.
- States:
  - IDLE, DONE: on I_START (with I_STOP low), clear prescaler, address, O_LENGTH and O_FULL, then go to RECORD (ARMED when the trigger feature is in). I_STOP in IDLE/DONE is ignored. START and STOP in the same cycle: STOP wins and the state is unchanged.
  - RECORD: the prescaler counts 0..PRESCALE and wraps. The tick is the cycle with prescaler == PRESCALE.
    - On tick: latch I_SAMPLE[15:8] and the current address.
    - Next cycle: O_WR_EN=1 with O_WR_ADDR/O_WR_DATA valid, address+1, O_LENGTH+1.
    - The first write therefore appears PRESCALE+2 cycles after the start cycle.
  - I_STOP in RECORD: go to DONE next cycle. If STOP coincides with a tick, that sample's write still completes and O_LENGTH includes it.
  - Full: the write to address 2^ADDR_W-1 transitions to DONE in the same cycle, sets O_FULL=1 and leaves O_LENGTH=2^ADDR_W. The address never wraps.
  - DONE: O_DONE pulses for one cycle on entry. O_LENGTH and O_FULL hold until the next accepted START.
- I_START in ARMED/RECORD is ignored.
- O_WR_ADDR/O_WR_DATA hold their last values when O_WR_EN=0.
- All outputs are registered.

Optional Feature:
- Macro: WAV_REC_TRIGGER_EN.
- Defined:
  - START enters ARMED. The prescaler runs but nothing is written.
  - The first tick where |I_SAMPLE[15:8] - 8'h80| >= TRIG_LEVEL writes that sample as address 0 and moves to RECORD.
  - I_STOP in ARMED goes to DONE with O_LENGTH=0.
- Not defined: the ARMED state and TRIG_LEVEL logic are absent, and START goes directly to RECORD.

Decomposition:
- Package wav_rec_pkg:
  - state enum {IDLE, ARMED, RECORD, DONE}.
  - function prescale(clk_hz, sample_hz).
  - localparam MID = 8'h80.
- One sub-module, wav_rec_tick: prescaler with clear input and tick output, width $clog2(PRESCALE+1).

Test Plan (CLK_HZ=16, SAMPLE_HZ=4, giving PRESCALE=3; ADDR_W=4):
- START pulse at cycle 0 with I_SAMPLE=16'hA5xx -> first O_WR_EN at cycle 5 with addr 0, data 8'hA5; subsequent writes every 4 cycles to addr 1, 2, ...
- Run without STOP -> 16 writes (addr 0..15), then O_DONE pulse, O_FULL=1, O_LENGTH=16; no 17th write.
- STOP on a tick cycle after 3 samples -> 4th write still occurs, then DONE with O_LENGTH=4 and O_FULL=0.
- START and STOP together in IDLE -> stays IDLE with no writes. START during RECORD -> ignored, address not reset.
- I_RSTn low mid-write -> O_WR_EN=0 asynchronously and all outputs 0; after release, a new START begins at addr 0.
- WAV_REC_TRIGGER_EN with TRIG_LEVEL=8: samples 0x82, 0x7C, 0x89 -> only 0x89 is written, at addr 0. STOP while ARMED -> DONE with O_LENGTH=0.
